jam_cost_arbiter: RTL

- Shares the single external cost ROM port (ROM_W, ROM_J -> ROM_COST) between NREQ job-assignment solver engines.
- A requester wins the port with round-robin fairness and holds it for a burst, typically one 8-row permutation sweep.
- Each accepted beat drives the ROM address; the returned cost is delivered back tagged to that requester.
- Sits between the solver array and the cost ROM at top level.

---
 rtl/jam_pkg.sv | 21 ++
 rtl/jam_cost_arbiter_if.sv | 27 ++
 rtl/jam_rr_pick.sv | 52 +++++
 rtl/jam_cost_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared constants, arbiter state encoding and a one-hot helper for the
// cost-ROM arbitration logic.
package jam_pkg;

  localparam int IDX_W    = 3;
  localparam int COST_W   = 7;
  localparam int NREQ_MAX = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // One-hot decode of an engine index; callers size-cast to their NREQ.
  function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
    logic [NREQ_MAX-1:0] vec;
    vec = {{(NREQ_MAX-1){1'b0}}, 1'b1} << idx;
    return vec;
  endfunction

endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Solver-side bus of the cost arbiter: packed per-engine requests and
// addresses, plus the grant and tagged cost return.
interface jam_cost_arbiter_if import jam_pkg::*; #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*IDX_W-1:0] req_w;
  logic [NREQ*IDX_W-1:0] req_j;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       gnt;
  logic [COST_W-1:0]     rd_cost;
  logic [NREQ-1:0]       rd_vld;

  // Solver array side.
  modport master (
    output req, req_w, req_j, req_last,
    input  gnt, rd_cost, rd_vld
  );

  // Arbiter side.
  modport slave (
    input  req, req_w, req_j, req_last,
    output gnt, rd_cost, rd_vld
  );

endinterface

// File: rtl/jam_rr_pick.sv
// Combinational round-robin picker: first set request bit searching from
// ptr upward, wrapping modulo NREQ.
module jam_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  logic [2*NREQ-1:0] rot_full;
  logic [NREQ-1:0]   rot;
  logic [PTR_W-1:0]  offset;
  logic [PTR_W:0]    sum;

  // Rotate requests so bit 0 is the engine at ptr.
  always_comb begin
    rot_full = {req, req} >> ptr;
    rot      = rot_full[NREQ-1:0];
  end

  // Lowest set bit of the rotated vector is the winner's distance from ptr.
  always_comb begin
    offset = '0;
    any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && rot[i]) begin
        offset = PTR_W'(i);
        any    = 1'b1;
      end else begin
        offset = offset;
      end
    end
  end

  // Map the distance back to an absolute engine index modulo NREQ.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PTR_W+1)'(NREQ)) begin
      winner = PTR_W'(sum - (PTR_W+1)'(NREQ));
    end else begin
      winner = PTR_W'(sum);
    end
  end

  // rot_full upper half only feeds the rotation.
  logic unused_rot;
  assign unused_rot = ^rot_full[2*NREQ-1:NREQ];

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin burst arbiter sharing one combinational cost ROM between
// NREQ solver engines. Grant is held for a burst; each accepted beat
// registers the ROM address and the cost returns two cycles later tagged
// with the engine that issued it, even across a change of owner.
module jam_cost_arbiter import jam_pkg::*; #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RST,
  jam_cost_arbiter_if.slave bus,
  output logic [IDX_W-1:0]  ROM_W,
  output logic [IDX_W-1:0]  ROM_J,
  input  logic [COST_W-1:0] ROM_COST,
  output logic              busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(NREQ - 1);

  arb_state_t        state, state_nxt;
  logic [NREQ-1:0]   gnt, gnt_nxt;
  logic [PTR_W-1:0]  owner, owner_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [NREQ-1:0]   owner_oh;
  logic [PTR_W-1:0]  owner_inc;

  logic [IDX_W-1:0]  sel_w, sel_j;
  logic              own_req, own_last, own_gnt;
  logic              accept, rel, abort;

  logic [NREQ-1:0]   tag1;
  logic [NREQ-1:0]   rd_vld;
  logic [COST_W-1:0] rd_cost;

  jam_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Select the owner's request, last flag, grant bit and addresses.
  always_comb begin
    sel_w    = '0;
    sel_j    = '0;
    own_req  = 1'b0;
    own_last = 1'b0;
    own_gnt  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PTR_W'(i)) begin
        sel_w    = bus.req_w[i*IDX_W +: IDX_W];
        sel_j    = bus.req_j[i*IDX_W +: IDX_W];
        own_req  = bus.req[i];
        own_last = bus.req_last[i];
        own_gnt  = gnt[i];
      end else begin
        sel_w = sel_w;
      end
    end
  end

  // Owner decode, pointer advance and beat/release qualification.
  always_comb begin
    owner_oh  = NREQ'(onehot(3'(owner)));
    owner_inc = (owner == PTR_TOP) ? '0 : owner + PTR_W'(1);
    accept    = (state == OWN) && own_req && own_gnt;
    abort     = (state == OWN) && !own_req;
    rel       = accept && (own_last || (beat_cnt == CNT_LAST));
  end

  // FSM state register plus the registered grant bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Next-state: grab the port on any request, drop it on release or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = OWN;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        if (rel || abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OWN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant, owner, rotating pointer and burst beat counter.
  always_comb begin
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_any) begin
          gnt_nxt   = NREQ'(onehot(3'(pick_idx)));
          owner_nxt = pick_idx;
        end else begin
          gnt_nxt   = '0;
          owner_nxt = owner;
        end
      end
      OWN: begin
        if (rel || abort) begin
          gnt_nxt = '0;
          ptr_nxt = owner_inc;
          cnt_nxt = '0;
        end else if (accept) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
        end else begin
          cnt_nxt = beat_cnt;
        end
      end
      default: begin
        gnt_nxt = '0;
        cnt_nxt = '0;
      end
    endcase
  end

  // Address stage: register ROM address on each beat and carry the owner tag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ROM_W <= '0;
      ROM_J <= '0;
      tag1  <= '0;
    end else begin
      if (accept) begin
        ROM_W <= sel_w;
        ROM_J <= sel_j;
      end
      tag1 <= accept ? owner_oh : '0;
    end
  end

  // Return stage: capture ROM data and strobe it to the tagged engine.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld  <= '0;
      rd_cost <= '0;
    end else begin
      rd_vld <= tag1;
      if (tag1 != '0) begin
        rd_cost <= ROM_COST;
      end
    end
  end

  assign busy        = (state == OWN) | (|tag1) | (|rd_vld);
  assign bus.gnt     = gnt;
  assign bus.rd_vld  = rd_vld;
  assign bus.rd_cost = rd_cost;

endmodule
